// File: rtl/lcd_timed_controller.sv
// rtl/lcd_timed_controller.sv - Avalon-MM slave to HD44780 character LCD bridge with cycle-counted E timing
module lcd_timed_controller #(
  parameter bit BUS_4BIT   = 1'b0,
  parameter int T_SETUP    = 2,
  parameter int T_E_HIGH   = 12,
  parameter int T_HOLD     = 2,
  parameter int T_RECOVERY = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int T_MAX_A = (T_SETUP > T_E_HIGH) ? T_SETUP : T_E_HIGH;
  localparam int T_MAX_B = (T_HOLD > T_RECOVERY) ? T_HOLD : T_RECOVERY;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // Counter is loaded with T-1 on state entry and the state ends when it reads zero.
  localparam logic [CW-1:0] LD_SETUP    = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_E_HIGH   = CW'(T_E_HIGH - 1);
  localparam logic [CW-1:0] LD_HOLD     = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_RECOVERY = CW'(T_RECOVERY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_E_HIGH, S_HOLD, S_RECOVER, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            nib_q, nib_d;
  logic            op_rd_q, op_rd_d;
  logic            rs_q, rs_d;
  logic            rw_q, rw_d;
  logic            e_q, e_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            drive_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nib_q   <= 1'b0;
      op_rd_q <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      e_q     <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      op_rd_q <= op_rd_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      e_q     <= e_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    op_rd_d = op_rd_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (read || write) begin
          op_rd_d = read;
          rs_d    = address[1];
          rw_d    = address[0];
          wdata_d = writedata;
          nib_d   = 1'b0;
          cnt_d   = LD_SETUP;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = LD_E_HIGH;
          state_d = S_E_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_E_HIGH: begin
        if (cnt_q == '0) begin
          if (op_rd_q) begin
            if (!BUS_4BIT)   rdata_d      = LCD_data;
            else if (!nib_q) rdata_d[7:4] = LCD_data[7:4];
            else             rdata_d[3:0] = LCD_data[7:4];
          end
          cnt_d   = LD_HOLD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (BUS_4BIT && !nib_q) begin
            nib_d   = 1'b1;
            cnt_d   = LD_SETUP;
            state_d = S_SETUP;
          end else begin
            cnt_d   = LD_RECOVERY;
            state_d = S_RECOVER;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // E is registered from the next state so it lines up exactly with E_HIGH.
    e_d = (state_d == S_E_HIGH);
  end

  assign drive_en = !op_rd_q &&
                    ((state_q == S_SETUP) || (state_q == S_E_HIGH) || (state_q == S_HOLD));

  generate
    if (BUS_4BIT) begin : g_bus4
      assign LCD_data[7:4] = drive_en ? (nib_q ? wdata_q[3:0] : wdata_q[7:4]) : 4'bzzzz;
      assign LCD_data[3:0] = 4'bzzzz;
    end else begin : g_bus8
      assign LCD_data = drive_en ? wdata_q : 8'bzzzz_zzzz;
    end
  endgenerate

  assign waitrequest = (read || write) && (state_q != S_DONE);
  assign readdata    = rdata_q;
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = rw_q;

endmodule

// File: tb/tb_lcd_timed_controller.sv
// tb/tb_lcd_timed_controller.sv - directed-vector bench for lcd_timed_controller in 8-bit and 4-bit builds
module tb_lcd_timed_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] address;
  logic [7:0] writedata;
  logic       rd8, wr8, rd4, wr4;
  wire  [7:0] rdata8, rdata4;
  wire        wait8, wait4, e8, e4, rs8, rs4, rw8, rw4;
  wire  [7:0] bus8, bus4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lcd_timed_controller u_dut8 (
    .clk(clk), .reset(rst), .address(address), .read(rd8), .write(wr8),
    .writedata(writedata), .readdata(rdata8), .waitrequest(wait8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_data(bus8)
  );

  lcd_timed_controller #(
    .BUS_4BIT(1'b1), .T_SETUP(1), .T_E_HIGH(1), .T_HOLD(1), .T_RECOVERY(1)
  ) u_dut4 (
    .clk(clk), .reset(rst), .address(address), .read(rd4), .write(wr4),
    .writedata(writedata), .readdata(rdata4), .waitrequest(wait4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_data(bus4)
  );

  // Undriven bus bits read as 1, so a released bus shows up as all-ones.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus8[i]);
    pullup (bus4[i]);
  end

  // LCD models: 8-bit returns 0x80; 4-bit returns 0x3 then 0xC on alternate pulses.
  logic       m4_tog, e4_prev;
  logic [3:0] m4_nib;
  assign m4_nib    = m4_tog ? 4'hC : 4'h3;
  assign bus8      = (e8 && rw8) ? 8'h80 : 8'bzzzz_zzzz;
  assign bus4[7:4] = (e4 && rw4) ? m4_nib : 4'bzzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m4_tog  <= 1'b0;
      e4_prev <= 1'b0;
    end else begin
      e4_prev <= e4;
      if (e4_prev && !e4) m4_tog <= ~m4_tog;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic       e_log [64];
  logic       w_log [64];
  logic [7:0] d_log [64];
  int done_at, n_wait, e_first, e_last, e_cnt, e_rise;

  task automatic xfer(input bit is4, input bit is_rd, input logic [1:0] a,
                      input logic [7:0] d, input bit hold);
    address   = a;
    writedata = d;
    if (is4) begin rd4 = is_rd; wr4 = !is_rd; end
    else     begin rd8 = is_rd; wr8 = !is_rd; end
    done_at = -1; n_wait = 0; e_first = -1; e_last = -1; e_cnt = 0; e_rise = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      w_log[c] = is4 ? wait4 : wait8;
      e_log[c] = is4 ? e4 : e8;
      d_log[c] = is4 ? bus4 : bus8;
      if (e_log[c]) begin
        if (e_first < 0) e_first = c;
        e_last = c;
        e_cnt++;
        if (c == 0 || !e_log[c-1]) e_rise++;
      end
      if (w_log[c]) n_wait++;
      if (!w_log[c]) begin
        done_at = c;
        if (!hold) begin rd8 = 0; wr8 = 0; rd4 = 0; wr4 = 0; end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (done_at < 0) begin rd8 = 0; wr8 = 0; rd4 = 0; wr4 = 0; end
  endtask

  int cnt_a, cnt_b, done1, last1;

  initial begin
    rst = 1'b1; address = 2'b00; writedata = 8'h00;
    rd8 = 0; wr8 = 0; rd4 = 0; wr4 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_e", e8, 0);
    check_eq("rst_rs_rw", {rs8, rw8}, 0);
    check_eq("rst_wait", wait8, 0);
    check_eq("rst_rdata", rdata8, 8'h00);
    check_eq("rst_bus", bus8, 8'hFF);
    @(negedge clk);

    // 8-bit write 0x41 to the data register
    xfer(0, 0, 2'b10, 8'h41, 0);
    check_eq("w8_done_at", done_at, 31);
    check_eq("w8_wait_cycles", n_wait, 31);
    check_eq("w8_e_first", e_first, 3);
    check_eq("w8_e_last", e_last, 14);
    check_eq("w8_e_cnt", e_cnt, 12);
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c <= 31; c++) begin
      if (c >= 1 && c <= 16) begin if (d_log[c] == 8'h41) cnt_a++; end
      else if (d_log[c] != 8'hFF) cnt_b++;
    end
    check_eq("w8_bus_driven", cnt_a, 16);
    check_eq("w8_bus_released", cnt_b, 0);
    check_eq("w8_rs_rw", {rs8, rw8}, 2'b10);
    check_eq("w8_rdata_untouched", rdata8, 8'h00);

    // 8-bit read of the busy-flag/address register
    xfer(0, 1, 2'b01, 8'h00, 0);
    check_eq("r8_done_at", done_at, 31);
    check_eq("r8_rdata", rdata8, 8'h80);
    check_eq("r8_rs_rw", {rs8, rw8}, 2'b01);
    cnt_a = 0;
    for (int c = 0; c <= 31; c++)
      if (d_log[c] != (e_log[c] ? 8'h80 : 8'hFF)) cnt_a++;
    check_eq("r8_bus_not_driven", cnt_a, 0);

    xfer(0, 0, 2'b10, 8'h33, 0);
    check_eq("w8b_done_at", done_at, 31);
    check_eq("w8b_rdata_kept", rdata8, 8'h80);

    // 4-bit write 0xA5 with all timings = 1
    xfer(1, 0, 2'b10, 8'hA5, 0);
    check_eq("w4_done_at", done_at, 8);
    check_eq("w4_wait_cycles", n_wait, 8);
    check_eq("w4_e_cnt", e_cnt, 2);
    check_eq("w4_e_pulses", e_rise, 2);
    check_eq("w4_nib_hi", d_log[2], 8'hAF);
    check_eq("w4_nib_lo", d_log[5], 8'h5F);
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c <= 8; c++) begin
      if (d_log[c][3:0] != 4'hF) cnt_a++;
      if ((c == 0 || c > 6) && d_log[c] != 8'hFF) cnt_b++;
    end
    check_eq("w4_low_nibble_z", cnt_a, 0);
    check_eq("w4_bus_released", cnt_b, 0);

    // 4-bit read assembles two nibbles
    xfer(1, 1, 2'b01, 8'h00, 0);
    check_eq("r4_done_at", done_at, 8);
    check_eq("r4_rdata", rdata4, 8'h3C);

    // back-to-back writes with write held through DONE
    xfer(0, 0, 2'b10, 8'h11, 1);
    done1 = done_at; last1 = e_last;
    xfer(0, 0, 2'b10, 8'h22, 0);
    check_eq("b2b_first_done", done1, 31);
    check_eq("b2b_second_done", done_at, 31);
    check_eq("b2b_e_gap", done1 - last1 + e_first, 20);
    check_eq("b2b_second_pulses", e_rise, 1);

    // reset on the 5th E_HIGH cycle
    address = 2'b10; writedata = 8'h5A; wr8 = 1;
    repeat (7) @(negedge clk);
    #1;
    check_eq("rst_mid_pre_e", e8, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_e", e8, 0);
    check_eq("rst_mid_bus", bus8, 8'hFF);
    wr8 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_post_wait", wait8, 0);
    check_eq("rst_post_pins", {e8, rs8, rw8}, 0);
    check_eq("rst_post_rdata", rdata8, 8'h00);
    @(negedge clk);
    xfer(0, 0, 2'b10, 8'h5A, 0);
    check_eq("rst_after_done_at", done_at, 31);
    check_eq("rst_after_e_first", e_first, 3);
    check_eq("rst_after_e_cnt", e_cnt, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
